// File: rtl/baud_tick_gen.sv
// baud_tick_gen: fractional clock divider producing oversample, mid-bit and end-of-bit ticks
module baud_tick_gen #(
  parameter int DIV_W            = 16,
  parameter int FRAC_W           = 4,
  parameter int OVERSAMPLE       = 16,
  parameter int DEFAULT_DIV_INT  = 8,
  parameter int DEFAULT_DIV_FRAC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              resync,
  input  logic              div_load,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  output logic              os_tick,
  output logic              mid_tick,
  output logic              bit_tick,
  output logic              div_pending
);
  localparam int OS_W = $clog2(OVERSAMPLE);
  logic [DIV_W:0]    cnt, period;
  logic [DIV_W-1:0]  act_int, sh_int;
  logic [FRAC_W-1:0] acc, act_frac, sh_frac;
  logic [FRAC_W:0]   acc_sum;
  logic [OS_W-1:0]   os_cnt;
  logic              ext, wrap, apply;
  always_comb begin
    period  = {1'b0, (act_int == '0) ? DIV_W'(1) : act_int} + (DIV_W+1)'(ext);
    wrap    = en && !resync && cnt == period - (DIV_W+1)'(1);
    acc_sum = {1'b0, acc} + {1'b0, act_frac};
    apply   = div_pending && (wrap || resync || !en);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      acc         <= '0;
      ext         <= 1'b0;
      os_cnt      <= '0;
      act_int     <= DIV_W'(DEFAULT_DIV_INT);
      act_frac    <= FRAC_W'(DEFAULT_DIV_FRAC);
      sh_int      <= DIV_W'(DEFAULT_DIV_INT);
      sh_frac     <= FRAC_W'(DEFAULT_DIV_FRAC);
      div_pending <= 1'b0;
      os_tick     <= 1'b0;
      mid_tick    <= 1'b0;
      bit_tick    <= 1'b0;
    end else begin
      os_tick  <= wrap;
      mid_tick <= wrap && os_cnt == OS_W'(OVERSAMPLE/2-1);
      bit_tick <= wrap && os_cnt == OS_W'(OVERSAMPLE-1);
      if (resync) begin
        cnt    <= '0;
        acc    <= '0;
        ext    <= 1'b0;
        os_cnt <= '0;
      end else if (wrap) begin
        cnt        <= '0;
        {ext, acc} <= acc_sum;
        os_cnt     <= os_cnt + OS_W'(1);
      end else if (en)
        cnt <= cnt + (DIV_W+1)'(1);
      // a load landing on a wrap takes effect for the very next period
      if (div_load && wrap) begin
        act_int  <= div_int;
        act_frac <= div_frac;
      end else if (apply) begin
        act_int  <= sh_int;
        act_frac <= sh_frac;
      end
      if (div_load) begin
        sh_int  <= div_int;
        sh_frac <= div_frac;
      end
      div_pending <= div_load ? !wrap : div_pending && !apply;
    end
  end
endmodule

// File: tb/tb_baud_tick_gen.sv
// tb_baud_tick_gen: scoreboard bench comparing tick cycle numbers against spec-derived timing
module tb_baud_tick_gen;
  logic clk = 1'b0, rst, en, resync, div_load;
  logic [15:0] div_int;
  logic [3:0] div_frac;
  logic os_tick, mid_tick, bit_tick, div_pending;
  int cyc = 0, n_cmp = 0, n_err = 0;
  int os_q[$], mid_q[$], bit_q[$], exp_os[$], exp_mid[$], exp_bit[$];

  always #5 clk = ~clk;

  baud_tick_gen dut (
    .clk(clk), .rst(rst), .en(en), .resync(resync), .div_load(div_load),
    .div_int(div_int), .div_frac(div_frac), .os_tick(os_tick),
    .mid_tick(mid_tick), .bit_tick(bit_tick), .div_pending(div_pending)
  );

  always @(posedge clk) begin
    #1;
    cyc++;
    if (os_tick) os_q.push_back(cyc);
    if (mid_tick) mid_q.push_back(cyc);
    if (bit_tick) bit_q.push_back(cyc);
  end

  task flush;
    os_q.delete(); mid_q.delete(); bit_q.delete();
    exp_os.delete(); exp_mid.delete(); exp_bit.delete();
  endtask

  task restart;
    resync = 1'b1;
    @(negedge clk);
    resync = 1'b0;
    flush();
  endtask

  task load(input logic [15:0] i, input logic [3:0] f);
    en = 1'b0; div_int = i; div_frac = f; div_load = 1'b1;
    @(negedge clk);
    div_load = 1'b0;
    @(negedge clk);
  endtask

  task test_reset;
    int base, e, a;
    rst = 1'b1; en = 1'b0; resync = 1'b0; div_load = 1'b0; div_int = '0; div_frac = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({os_tick, mid_tick, bit_tick, div_pending} !== 4'b0) begin
      n_err++; $display("FAIL reset outputs: got %b, want 0000", {os_tick, mid_tick, bit_tick, div_pending});
    end
    rst = 1'b0; en = 1'b1; flush(); base = cyc;
    for (int k = 1; k <= 16; k++) exp_os.push_back(base + 8*k);
    exp_mid.push_back(base + 64);
    exp_bit.push_back(base + 128);
    repeat (130) @(negedge clk);
    while (exp_os.size() > 0) begin
      e = exp_os.pop_front(); a = os_q.size() > 0 ? os_q.pop_front() : -1; n_cmp++;
      if (a !== e) begin n_err++; $display("FAIL default os_tick: got cyc %0d, want %0d", a - base, e - base); end
    end
    e = exp_mid.pop_front(); a = mid_q.size() > 0 ? mid_q.pop_front() : -1; n_cmp++;
    if (a !== e) begin n_err++; $display("FAIL default mid_tick: got cyc %0d, want %0d", a - base, e - base); end
    e = exp_bit.pop_front(); a = bit_q.size() > 0 ? bit_q.pop_front() : -1; n_cmp++;
    if (a !== e) begin n_err++; $display("FAIL default bit_tick: got cyc %0d, want %0d", a - base, e - base); end
    n_cmp++;
    if (os_q.size() + mid_q.size() + bit_q.size() != 0) begin
      n_err++; $display("FAIL default extra ticks: got %0d, want 0", os_q.size() + mid_q.size() + bit_q.size());
    end
  endtask

  task test_frac;
    int base, t, e, a, span;
    load(16'd4, 4'd8);
    en = 1'b1; restart(); base = cyc; t = 0;
    for (int k = 1; k <= 18; k++) begin
      t += (k > 2 && k % 2 == 1) ? 5 : 4;
      exp_os.push_back(base + t);
      if (k == 8) exp_mid.push_back(base + t);
      if (k == 16) exp_bit.push_back(base + t);
    end
    repeat (80) @(negedge clk);
    span = os_q.size() >= 17 ? os_q[16] - os_q[0] : -1;
    n_cmp++;
    if (span !== 72) begin n_err++; $display("FAIL frac span periods 2..17: got %0d, want 72", span); end
    while (exp_os.size() > 0) begin
      e = exp_os.pop_front(); a = os_q.size() > 0 ? os_q.pop_front() : -1; n_cmp++;
      if (a !== e) begin n_err++; $display("FAIL frac os_tick: got cyc %0d, want %0d", a - base, e - base); end
    end
    e = exp_mid.pop_front(); a = mid_q.size() > 0 ? mid_q.pop_front() : -1; n_cmp++;
    if (a !== e) begin n_err++; $display("FAIL frac mid_tick: got cyc %0d, want %0d", a - base, e - base); end
    e = exp_bit.pop_front(); a = bit_q.size() > 0 ? bit_q.pop_front() : -1; n_cmp++;
    if (a !== e) begin n_err++; $display("FAIL frac bit_tick: got cyc %0d, want %0d", a - base, e - base); end
    n_cmp++;
    if (os_q.size() + mid_q.size() + bit_q.size() != 0) begin
      n_err++; $display("FAIL frac extra ticks: got %0d, want 0", os_q.size() + mid_q.size() + bit_q.size());
    end
  endtask

  task test_enable;
    int base, e, a;
    load(16'd8, 4'd0);
    en = 1'b1; restart();
    repeat (3) @(negedge clk);
    en = 1'b0;
    repeat (10) @(negedge clk);
    en = 1'b1; base = cyc;
    exp_os.push_back(base + 5);
    exp_os.push_back(base + 13);
    repeat (14) @(negedge clk);
    while (exp_os.size() > 0) begin
      e = exp_os.pop_front(); a = os_q.size() > 0 ? os_q.pop_front() : -1; n_cmp++;
      if (a !== e) begin n_err++; $display("FAIL enable os_tick: got cyc %0d, want %0d", a - base, e - base); end
    end
    n_cmp++;
    if (os_q.size() + mid_q.size() + bit_q.size() != 0) begin
      n_err++; $display("FAIL enable extra ticks: got %0d, want 0", os_q.size() + mid_q.size() + bit_q.size());
    end
  endtask

  task test_resync;
    int base, base2, e, a;
    en = 1'b1; restart(); base = cyc;
    for (int k = 1; k <= 11; k++) exp_os.push_back(base + 8*k);
    exp_mid.push_back(base + 64);
    repeat (92) @(negedge clk);
    resync = 1'b1; base2 = cyc;
    @(negedge clk);
    resync = 1'b0;
    n_cmp++;
    if ({os_tick, mid_tick, bit_tick} !== 3'b0) begin
      n_err++; $display("FAIL resync cycle ticks: got %b, want 000", {os_tick, mid_tick, bit_tick});
    end
    for (int k = 1; k <= 16; k++) exp_os.push_back(base2 + 1 + 8*k);
    exp_mid.push_back(base2 + 65);
    exp_bit.push_back(base2 + 129);
    repeat (130) @(negedge clk);
    while (exp_os.size() > 0) begin
      e = exp_os.pop_front(); a = os_q.size() > 0 ? os_q.pop_front() : -1; n_cmp++;
      if (a !== e) begin n_err++; $display("FAIL resync os_tick: got cyc %0d, want %0d", a - base, e - base); end
    end
    while (exp_mid.size() > 0) begin
      e = exp_mid.pop_front(); a = mid_q.size() > 0 ? mid_q.pop_front() : -1; n_cmp++;
      if (a !== e) begin n_err++; $display("FAIL resync mid_tick: got cyc %0d, want %0d", a - base, e - base); end
    end
    e = exp_bit.pop_front(); a = bit_q.size() > 0 ? bit_q.pop_front() : -1; n_cmp++;
    if (a !== e) begin n_err++; $display("FAIL resync bit_tick: got cyc %0d, want %0d", a - base, e - base); end
    n_cmp++;
    if (os_q.size() + mid_q.size() + bit_q.size() != 0) begin
      n_err++; $display("FAIL resync extra ticks: got %0d, want 0", os_q.size() + mid_q.size() + bit_q.size());
    end
  endtask

  task test_div_load;
    int base, e, a;
    en = 1'b1; restart();
    repeat (2) @(negedge clk);
    div_int = 16'd4; div_frac = 4'd0; div_load = 1'b1; base = cyc;
    for (int k = 0; k < 4; k++) exp_os.push_back(base + 6 + 4*k);
    @(negedge clk);
    div_load = 1'b0;
    n_cmp++;
    if (div_pending !== 1'b1) begin n_err++; $display("FAIL load pending after strobe: got %b, want 1", div_pending); end
    repeat (4) @(negedge clk);
    n_cmp++;
    if (div_pending !== 1'b1) begin n_err++; $display("FAIL load pending before boundary: got %b, want 1", div_pending); end
    @(negedge clk);
    n_cmp++;
    if (div_pending !== 1'b0) begin n_err++; $display("FAIL load pending after boundary: got %b, want 0", div_pending); end
    repeat (12) @(negedge clk);
    while (exp_os.size() > 0) begin
      e = exp_os.pop_front(); a = os_q.size() > 0 ? os_q.pop_front() : -1; n_cmp++;
      if (a !== e) begin n_err++; $display("FAIL load os_tick: got cyc %0d, want %0d", a - base, e - base); end
    end
    n_cmp++;
    if (os_q.size() + mid_q.size() + bit_q.size() != 0) begin
      n_err++; $display("FAIL load extra ticks: got %0d, want 0", os_q.size() + mid_q.size() + bit_q.size());
    end
  endtask

  task test_zero_and_rst;
    int base, e, a;
    load(16'd0, 4'd0);
    en = 1'b1; restart(); base = cyc;
    for (int k = 1; k <= 20; k++) exp_os.push_back(base + k);
    exp_mid.push_back(base + 8);
    exp_bit.push_back(base + 16);
    repeat (20) @(negedge clk);
    while (exp_os.size() > 0) begin
      e = exp_os.pop_front(); a = os_q.size() > 0 ? os_q.pop_front() : -1; n_cmp++;
      if (a !== e) begin n_err++; $display("FAIL div0 os_tick: got cyc %0d, want %0d", a - base, e - base); end
    end
    e = exp_mid.pop_front(); a = mid_q.size() > 0 ? mid_q.pop_front() : -1; n_cmp++;
    if (a !== e) begin n_err++; $display("FAIL div0 mid_tick: got cyc %0d, want %0d", a - base, e - base); end
    e = exp_bit.pop_front(); a = bit_q.size() > 0 ? bit_q.pop_front() : -1; n_cmp++;
    if (a !== e) begin n_err++; $display("FAIL div0 bit_tick: got cyc %0d, want %0d", a - base, e - base); end
    en = 1'b0; div_int = 16'd5; div_load = 1'b1;
    @(negedge clk);
    div_load = 1'b0;
    n_cmp++;
    if (div_pending !== 1'b1) begin n_err++; $display("FAIL pre-reset pending: got %b, want 1", div_pending); end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({os_tick, mid_tick, bit_tick, div_pending} !== 4'b0) begin
      n_err++; $display("FAIL mid-run reset outputs: got %b, want 0000", {os_tick, mid_tick, bit_tick, div_pending});
    end
    rst = 1'b0; en = 1'b1; flush(); base = cyc;
    exp_os.push_back(base + 8);
    exp_os.push_back(base + 16);
    repeat (17) @(negedge clk);
    while (exp_os.size() > 0) begin
      e = exp_os.pop_front(); a = os_q.size() > 0 ? os_q.pop_front() : -1; n_cmp++;
      if (a !== e) begin n_err++; $display("FAIL restored default os_tick: got cyc %0d, want %0d", a - base, e - base); end
    end
    n_cmp++;
    if (os_q.size() + mid_q.size() + bit_q.size() != 0) begin
      n_err++; $display("FAIL restored extra ticks: got %0d, want 0", os_q.size() + mid_q.size() + bit_q.size());
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_frac();
    test_enable();
    test_resync();
    test_div_load();
    test_zero_and_rst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
